// File: rtl/gpio_input_conditioner_if.sv
// Pin-side bus of the GPIO input conditioner.
// The master side drives the raw pins, the edge enables and the event clears.
// The slave side (the conditioner) returns the clean levels, the sticky flags
// and the interrupt line.
interface gpio_input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] gpio_pins_in;
  logic [WIDTH-1:0] edge_rise_en;
  logic [WIDTH-1:0] edge_fall_en;
  logic [WIDTH-1:0] event_clear;
  logic             event_clear_strobe;
  logic [WIDTH-1:0] gpio_data_in;
  logic [WIDTH-1:0] gpio_event;
  logic             interrupt;

  modport master (
    output gpio_pins_in,
    output edge_rise_en,
    output edge_fall_en,
    output event_clear,
    output event_clear_strobe,
    input  gpio_data_in,
    input  gpio_event,
    input  interrupt
  );

  modport slave (
    input  gpio_pins_in,
    input  edge_rise_en,
    input  edge_fall_en,
    input  event_clear,
    input  event_clear_strobe,
    output gpio_data_in,
    output gpio_event,
    output interrupt
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Conditions raw GPIO pins for the Picoblaze GPIO read path.
// Each bit is taken through a 2-flop synchronizer and a counter debouncer.
// The accepted level is then edge-detected into sticky event flags, and the
// OR of those flags is registered as the interrupt line.
// Edges are only looked at on the cycle a new level is accepted, so the
// enables cannot create or remove a flag on any other cycle.
module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input logic                     clk,
  input logic                     reset,
  gpio_input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] event_q;
  logic             irq_q;

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] set_event;
  logic [WIDTH-1:0] clr_event;

  // Accept when the disagreeing level has persisted for the full count.
  // The edge direction is the level being accepted.
  always_comb begin
    accept    = '0;
    set_event = '0;
    clr_event = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != data_q[i]) && (cnt[i] == TERM_CNT);
    end
    set_event = accept & ((sync2 & bus.edge_rise_en) | (~sync2 & bus.edge_fall_en));
    clr_event = bus.event_clear_strobe ? bus.event_clear : '0;
  end

  // Two-stage synchronizer with no logic between the stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.gpio_pins_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce counters: run while the levels disagree, restart on agreement or accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == data_q[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Accepted levels, sticky flags (set beats clear) and registered interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      data_q  <= (data_q & ~accept) | (sync2 & accept);
      event_q <= set_event | (event_q & ~clr_event);
      irq_q   <= |event_q;
    end
  end

  assign bus.gpio_data_in = data_q;
  assign bus.gpio_event   = event_q;
  assign bus.interrupt    = irq_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES = 4.
// The reference model states debounce as a sliding window: a bit takes a new
// level when its last D synchronized samples (pins seen 2..D+1 edges ago) all
// disagree with the current level. Flags, clears and the interrupt follow
// from the accepted transitions. Hand-computed literals pin key cycles.
module tb_gpio_input_conditioner;
  localparam int W = 8;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_input_conditioner_if #(.WIDTH(W)) bus ();

  gpio_input_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] hist [0:D] = '{default: '0};
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_ev   = '0;
  logic         m_irq  = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic [W-1:0] acc, set, clr, old_data, old_ev;
    if (!reset) begin
      for (int k = 0; k <= D; k++) hist[k] = '0;
      m_data = '0;
      m_ev   = '0;
      m_irq  = 1'b0;
    end else begin
      old_data = m_data;
      old_ev   = m_ev;
      acc = '1;
      for (int k = 0; k < D; k++) acc = acc & (hist[k] ^ old_data);
      set = acc & ((~old_data & bus.edge_rise_en) | (old_data & bus.edge_fall_en));
      clr = bus.event_clear_strobe ? bus.event_clear : '0;
      m_data = old_data ^ acc;
      m_ev   = set | (old_ev & ~clr);
      m_irq  = |old_ev;
      for (int k = 0; k < D; k++) hist[k] = hist[k+1];
      hist[D] = bus.gpio_pins_in;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_data", bus.gpio_data_in, m_data);
    check("model_event", bus.gpio_event, m_ev);
    check("model_irq", {7'd0, bus.interrupt}, {7'd0, m_irq});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.event_clear        = '1;
    bus.event_clear_strobe = 1'b1;
    step(1);
    bus.event_clear_strobe = 1'b0;
    bus.event_clear        = '0;
    step(2);
  endtask

  initial begin
    bus.gpio_pins_in       = 8'hFF;
    bus.edge_rise_en       = '0;
    bus.edge_fall_en       = '0;
    bus.event_clear        = '0;
    bus.event_clear_strobe = 1'b0;
    #1 reset = 1'b0;

    // Reset holds everything at zero even with all pins high.
    step(3);
    check("rst_data", bus.gpio_data_in, 8'h00);
    check("rst_event", bus.gpio_event, 8'h00);
    check("rst_irq", {7'd0, bus.interrupt}, 8'h00);
    reset = 1'b1;
    step(5);
    check("rst_rel_e5", bus.gpio_data_in, 8'h00);
    step(1);
    check("rst_rel_e6", bus.gpio_data_in, 8'hFF);

    // Settle low with no enables: no events.
    bus.gpio_pins_in = 8'h00;
    step(8);
    check("settle_low", bus.gpio_data_in, 8'h00);
    check("settle_noev", bus.gpio_event, 8'h00);

    // Rise event on bit 0, then clear.
    bus.edge_rise_en = 8'h01;
    bus.gpio_pins_in = 8'h01;
    step(5);
    check("rise_e5_data", bus.gpio_data_in, 8'h00);
    check("rise_e5_ev", bus.gpio_event, 8'h00);
    step(1);
    check("rise_e6_data", bus.gpio_data_in, 8'h01);
    check("rise_e6_ev", bus.gpio_event, 8'h01);
    check("rise_e6_irq", {7'd0, bus.interrupt}, 8'h00);
    step(1);
    check("rise_e7_irq", {7'd0, bus.interrupt}, 8'h01);
    bus.event_clear        = 8'h01;
    bus.event_clear_strobe = 1'b1;
    step(1);
    bus.event_clear_strobe = 1'b0;
    bus.event_clear        = '0;
    check("clr_ev", bus.gpio_event, 8'h00);
    check("clr_irq_lag", {7'd0, bus.interrupt}, 8'h01);
    step(1);
    check("clr_irq", {7'd0, bus.interrupt}, 8'h00);

    // Glitch on bit 3: 3 cycles rejected, 4 cycles accepted.
    bus.edge_rise_en = 8'h08;
    bus.gpio_pins_in = 8'h09;
    step(3);
    bus.gpio_pins_in = 8'h01;
    step(8);
    check("glitch_data", bus.gpio_data_in, 8'h01);
    check("glitch_ev", bus.gpio_event, 8'h00);
    check("glitch_irq", {7'd0, bus.interrupt}, 8'h00);
    bus.gpio_pins_in = 8'h09;
    step(4);
    bus.gpio_pins_in = 8'h01;
    step(2);
    check("pulse4_data", bus.gpio_data_in, 8'h09);
    check("pulse4_ev", bus.gpio_event, 8'h08);
    step(6);
    check("pulse4_back", bus.gpio_data_in, 8'h01);
    clear_all();

    // Fall on bit 7 enabled; rise on bit 7 masked.
    bus.edge_rise_en = 8'h00;
    bus.edge_fall_en = 8'h00;
    bus.gpio_pins_in = 8'h81;
    step(8);
    check("fall_pre_data", bus.gpio_data_in, 8'h81);
    check("fall_pre_ev", bus.gpio_event, 8'h00);
    bus.edge_fall_en = 8'h80;
    bus.gpio_pins_in = 8'h01;
    step(6);
    check("fall_data", bus.gpio_data_in, 8'h01);
    check("fall_ev", bus.gpio_event, 8'h80);
    bus.gpio_pins_in = 8'h81;
    step(6);
    check("mask_data", bus.gpio_data_in, 8'h81);
    check("mask_ev", bus.gpio_event, 8'h80);
    bus.edge_fall_en = 8'h00;
    bus.gpio_pins_in = 8'h01;
    step(8);
    clear_all();

    // Set/clear collision on bit 2 at its accept edge: set wins.
    bus.edge_rise_en = 8'h04;
    bus.gpio_pins_in = 8'h05;
    step(5);
    bus.event_clear        = 8'h04;
    bus.event_clear_strobe = 1'b1;
    step(1);
    bus.event_clear_strobe = 1'b0;
    bus.event_clear        = '0;
    check("collide_ev", bus.gpio_event, 8'h04);
    check("collide_data", bus.gpio_data_in, 8'h05);
    step(2);
    clear_all();

    // Async reset mid-count on bit 1, then a full 4+2 is needed again.
    bus.edge_rise_en = 8'h00;
    bus.gpio_pins_in = 8'h07;
    step(4);
    #2 reset = 1'b0;
    #1;
    check("arst_data", bus.gpio_data_in, 8'h00);
    check("arst_ev", bus.gpio_event, 8'h00);
    check("arst_irq", {7'd0, bus.interrupt}, 8'h00);
    #3 reset = 1'b1;
    step(1);
    step(4);
    check("arst_e5", bus.gpio_data_in, 8'h00);
    step(1);
    check("arst_e6", bus.gpio_data_in, 8'h07);
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Sits directly upstream of the Picoblaze GPIO register block.
- Conditions raw pin inputs into a clean, stable bus that drives that block's gpio_data_in read path.
- Each bit is synchronized into the clk domain, debounced, and edge-detected. Enabled edges latch into sticky event flags.
- The flags are ORed into a single interrupt line for the processor.

Parameters:
WIDTH, 8, number of GPIO bits conditioned
DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronized level must persist before being accepted (legal range 1..65535)
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
gpio_pins_in  input  WIDTH  raw asynchronous pin levels
edge_rise_en  input  WIDTH  per-bit enable: accepted 0->1 transition sets event flag
edge_fall_en  input  WIDTH  per-bit enable: accepted 1->0 transition sets event flag
event_clear  input  WIDTH  per-bit clear mask, qualified by event_clear_strobe
event_clear_strobe  input  1  one-cycle pulse applying event_clear
gpio_data_in  output  WIDTH  debounced, synchronized pin levels
gpio_event  output  WIDTH  sticky per-bit edge event flags
interrupt  output  1  registered OR of gpio_event

Behaviour:
- Reset (reset==0, asynchronous):
  - both sync stages, gpio_data_in, every debounce counter, gpio_event and interrupt go to 0.
  - Release is sampled on the next rising clk edge.
- Synchronizer: two flops per bit, sync1 <= gpio_pins_in, sync2 <= sync1. No logic between the stages.
- Debounce, per bit i, each clk edge:
  - sync2[i] == gpio_data_in[i]: counter[i] <= 0.
  - sync2[i] != gpio_data_in[i] and counter[i] < DEBOUNCE_CYCLES-1: counter[i] <= counter[i]+1.
  - sync2[i] != gpio_data_in[i] and counter[i] == DEBOUNCE_CYCLES-1 ("accept"): gpio_data_in[i] <= sync2[i], counter[i] <= 0.
- Debounce timing consequences:
  - A pin level held steady is accepted DEBOUNCE_CYCLES+2 clk edges after the first edge that samples it into sync1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 resets the counter and produces no output change.
  - DEBOUNCE_CYCLES=1 gives a pure 2-flop synchronizer.
- Edge detection is evaluated on the accept edge only:
  - rise[i] = accept & sync2[i] & edge_rise_en[i]
  - fall[i] = accept & ~sync2[i] & edge_fall_en[i]
- Event flags, per bit:
  - gpio_event[i] <= 1 on the same edge gpio_data_in[i] updates, if rise[i] | fall[i].
  - Otherwise gpio_event[i] <= 0 if event_clear_strobe & event_clear[i].
  - Otherwise it holds.
  - A simultaneous set and clear on one bit leaves the flag set (set wins).
  - A clear on an already-0 flag has no effect.
  - Clearing one bit never affects the others.
- Enables are sampled on the accept edge only. Changing an enable never creates or removes an existing event.
- interrupt <= |gpio_event, registered, so it asserts exactly one cycle after the first flag sets. It deasserts one cycle after the last flag clears.
- Bits are fully independent: simultaneous accepts on several bits each set their own flags.

Test Plan:
(DEBOUNCE_CYCLES=4 unless stated)
- Reset: hold reset=0 with gpio_pins_in=8'hFF -> gpio_data_in=8'h00, gpio_event=8'h00, interrupt=0. After release and a steady 8'hFF, gpio_data_in=8'hFF at edge 6 (4+2).
- Rise event: edge_rise_en=8'h01, pin0 0->1 held -> gpio_data_in[0] and gpio_event=8'h01 update on edge 6; interrupt=1 on edge 7. Pulse event_clear=8'h01 with the strobe -> gpio_event=8'h00 next edge, interrupt=0 one edge later.
- Glitch reject: pin3 high for 3 cycles then low -> gpio_data_in[3] stays 0, counter returns to 0, no event or interrupt. Repeat with 4 cycles high -> accepted.
- Fall and enable masking: edge_fall_en=8'h80, edge_rise_en=8'h00, pin7 1->0 -> gpio_event=8'h80. Pin7 0->1 -> no new flag, but gpio_data_in[7] still follows the pin.
- Set/clear collision: strobe clear of bit 2 on the exact accept edge of an enabled rise on bit 2 -> gpio_event[2]=1 afterwards.
- Async reset mid-count: assert reset for less than one clk period during a count at 2 -> all outputs 0 immediately. After release, a full 4+2 cycles are again required for acceptance.
